// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Host-side writer for the 8-bit core's instruction-memory load port.
// Receives a framed byte stream (SYNC, ADDR, LEN, D0..D(LEN-1), CSUM) over a
// valid/ready interface and buffers the payload. Once the checksum is verified,
// the loader commits the payload to instruction memory as back-to-back
// single-cycle writes. The core is held in load mode while the payload is
// received and committed.
//
// Handshake: a byte transfers on a rising clk edge where in_valid & in_ready.
// in_ready is high in every state except COMMIT. The source may drop in_valid
// at any time, and reception simply waits.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   [7:0] stream byte
//   in_valid   in   in_data valid this cycle
//   in_ready   out  loader accepts a byte this cycle
//   mem_we     out  instruction-memory write strobe (one cycle per byte)
//   mem_addr   out  [ADDR_W-1:0] write address (holds when mem_we=0)
//   mem_wdata  out  [7:0] write data (holds when mem_we=0)
//   cpu_hold   out  core write-mode: high from LEN accept to end of commit
//   done       out  one-cycle pulse after a successful commit
//   err        out  sticky error flag, cleared by the next accepted SYNC
//   busy       out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int         MEM_DEPTH = 25,
    parameter int         ADDR_W    = 5,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_ADDR = 3'd1;
    localparam logic [2:0] S_GET_LEN  = 3'd2;
    localparam logic [2:0] S_GET_DATA = 3'd3;
    localparam logic [2:0] S_GET_CSUM = 3'd4;
    localparam logic [2:0] S_COMMIT   = 3'd5;
    localparam logic [2:0] S_ERROR    = 3'd6;

    // Current FSM state; kept as a plain named register for probing.
    logic [2:0] state;

    logic [7:0] start_addr;   // ADDR byte of the current frame
    logic [7:0] len;          // LEN byte of the current frame
    logic [7:0] idx;          // data byte index while receiving, write index while committing
    logic [7:0] sum;          // running checksum over ADDR, LEN and data
    logic [7:0] buffer [MEM_DEPTH];

    logic       accept;
    logic [7:0] sum_next;
    logic [7:0] idx_next;
    logic [8:0] end_addr;     // ADDR+LEN with a ninth bit so overflow cannot wrap

    assign in_ready = (state != S_COMMIT);
    assign busy     = (state != S_IDLE);
    assign accept   = in_valid & in_ready;
    assign sum_next = sum + in_data;
    assign idx_next = idx + 8'd1;
    assign end_addr = {1'b0, start_addr} + {1'b0, in_data};

    // Payload buffer. No reset: its contents are only read after being
    // written by the current frame.
    always_ff @(posedge clk) begin
        if (state == S_GET_DATA && accept) begin
            buffer[idx[ADDR_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            start_addr <= 8'd0;
            len        <= 8'd0;
            idx        <= 8'd0;
            sum        <= 8'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done   <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        state <= S_GET_ADDR;
                        err   <= 1'b0;
                        sum   <= 8'd0;
                    end
                end

                S_GET_ADDR: begin
                    if (accept) begin
                        start_addr <= in_data;
                        sum        <= sum_next;
                        if ({1'b0, in_data} >= 9'(MEM_DEPTH)) begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_GET_LEN;
                        end
                    end
                end

                S_GET_LEN: begin
                    if (accept) begin
                        len <= in_data;
                        sum <= sum_next;
                        idx <= 8'd0;
                        if (in_data == 8'd0 || end_addr > 9'(MEM_DEPTH)) begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= S_GET_DATA;
                            cpu_hold <= 1'b1;
                        end
                    end
                end

                S_GET_DATA: begin
                    if (accept) begin
                        sum <= sum_next;
                        idx <= idx_next;
                        if (idx_next == len) begin
                            state <= S_GET_CSUM;
                        end
                    end
                end

                S_GET_CSUM: begin
                    if (accept) begin
                        sum <= sum_next;
                        if (sum_next == 8'd0) begin
                            // Issue write 0 on this edge so the first mem_we
                            // appears the cycle after the CSUM byte.
                            state     <= S_COMMIT;
                            mem_we    <= 1'b1;
                            mem_addr  <= start_addr[ADDR_W-1:0];
                            mem_wdata <= buffer[0];
                            idx       <= 8'd1;
                        end else begin
                            state    <= S_ERROR;
                            err      <= 1'b1;
                            cpu_hold <= 1'b0;
                        end
                    end
                end

                S_COMMIT: begin
                    if (idx == len) begin
                        // Last write is on the bus now; release the core.
                        state    <= S_IDLE;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= start_addr[ADDR_W-1:0] + idx[ADDR_W-1:0];
                        mem_wdata <= buffer[idx[ADDR_W-1:0]];
                        idx       <= idx_next;
                    end
                end

                S_ERROR: begin
                    // err and cpu_hold were already updated on entry.
                    state <= S_IDLE;
                end

                default: begin
                    state    <= S_IDLE;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Bench for prog_loader. Frames are driven through the valid/ready input; a
// frame-level reference model decides from the frame rules whether the frame
// loads, and if so pushes the expected (address, data) writes into exp_q. A
// monitor on the falling clock edge pops and compares every memory write.
// -----------------------------------------------------------------------------
module tb_prog_loader;
    localparam int MEM_DEPTH = 25;
    localparam int ADDR_W    = 5;

    // Clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]        in_data  = 8'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic              busy;

    prog_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    int  checks        = 0;
    int  failures      = 0;
    int  done_seen     = 0;
    int  done_expected = 0;
    int  writes_seen   = 0;
    bit  stall_en      = 1'b0;

    logic [12:0] exp_q[$];   // {addr[4:0], data[7:0]}
    logic [12:0] mon_e;
    logic [7:0]  fd[$];      // payload of the frame being built

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            writes_seen++;
            check("commit_in_ready", in_ready, 0);
            check("commit_cpu_hold", cpu_hold, 1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=addr %0d data %0h expected=no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", mem_addr, mon_e[12:8]);
                check("write_data", mem_wdata, mon_e[7:0]);
            end
        end
        if (rst_n && done) begin
            done_seen++;
            check("done_expected", done_seen <= done_expected, 1);
            check("done_cpu_hold", cpu_hold, 0);
            check("done_mem_we", mem_we, 0);
        end
    end

    // Driver: one byte through the handshake, with optional idle gaps.
    task automatic send_byte(input logic [7:0] b);
        int n;
        if (stall_en) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(posedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    // Sends a frame using fd as payload. The model decides the outcome from
    // the frame rules and queues the expected writes.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] l,
                              input logic [7:0] c, input bit settle);
        bit hdr_ok;
        bit ok;
        int s;
        int n;
        hdr_ok = (int'(a) < MEM_DEPTH) && (l != 8'd0) && (int'(a) + int'(l) <= MEM_DEPTH);
        ok = 1'b0;
        send_byte(8'hA5);
        check("busy_after_sync", busy, 1);
        send_byte(a);
        if (int'(a) < MEM_DEPTH) begin
            send_byte(l);
            if (hdr_ok) begin
                check("cpu_hold_after_len", cpu_hold, 1);
                s = int'(a) + int'(l) + int'(c);
                for (int k = 0; k < int'(l); k++) s += int'(fd[k]);
                ok = (s % 256) == 0;
                if (ok) begin
                    for (int k = 0; k < int'(l); k++) exp_q.push_back({5'(int'(a) + k), fd[k]});
                    done_expected++;
                end
                for (int k = 0; k < int'(l); k++) send_byte(fd[k]);
                send_byte(c);
            end
        end
        if (settle) begin
            n = 0;
            while (ok && done_seen < done_expected && n < 300) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (ok) check("done_seen", done_seen, done_expected);
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            check("err_after_frame", err, !ok);
            check("busy_after_frame", busy, 0);
            check("cpu_hold_after_frame", cpu_hold, 0);
            check("pending_writes", exp_q.size(), 0);
        end
    endtask

    task automatic rand_frame(input logic [7:0] a, input logic [7:0] l, input bit bad);
        int s;
        logic [7:0] c;
        fd.delete();
        s = int'(a) + int'(l);
        for (int k = 0; k < int'(l) && k < MEM_DEPTH; k++) begin
            fd.push_back(8'($urandom_range(0, 255)));
            s += int'(fd[k]);
        end
        c = 8'((256 - (s % 256)) % 256);
        if (bad) c = c + 8'd1;
        send_frame(a, l, c, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int base;
        int n;
        logic [7:0] c;
        int s;

        // Reset state
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Known frame: load 01,2A,0A at address 0
        fd = '{8'h01, 8'h2A, 8'h0A};
        send_frame(8'h00, 8'h03, 8'hC8, 1'b1);

        // Bad checksum, then a good frame clears err
        fd = '{8'h01, 8'h2A, 8'h0A};
        send_frame(8'h00, 8'h03, 8'hC7, 1'b1);
        rand_frame(8'd5, 8'd4, 1'b0);

        // Boundaries
        rand_frame(8'h16, 8'd3, 1'b0);   // ends exactly at 24
        rand_frame(8'h17, 8'd3, 1'b0);   // overflows
        rand_frame(8'h04, 8'd0, 1'b0);   // zero length
        rand_frame(8'h19, 8'd2, 1'b0);   // address out of range
        rand_frame(8'h00, 8'd25, 1'b0);  // whole memory

        // Garbage before SYNC, with random stalls inside the frame
        stall_en = 1'b1;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        check("garbage_idle", busy, 0);
        fd = '{8'h01, 8'h2A, 8'h0A};
        send_frame(8'h00, 8'h03, 8'hC8, 1'b1);

        // Random frames
        for (int i = 0; i < 24; i++) begin
            stall_en = ($urandom_range(0, 1) == 1);
            rand_frame(8'($urandom_range(0, 26)), 8'($urandom_range(0, 8)),
                       $urandom_range(0, 3) == 0);
        end
        stall_en = 1'b0;

        // Reset during the second write of a five-byte commit
        fd.delete();
        s = 3 + 5;
        for (int k = 0; k < 5; k++) begin
            fd.push_back(8'($urandom_range(0, 255)));
            s += int'(fd[k]);
        end
        c = 8'((256 - (s % 256)) % 256);
        base = writes_seen;
        send_frame(8'd3, 8'd5, c, 1'b0);
        n = 0;
        while (writes_seen < base + 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("second_write_seen", writes_seen, base + 2);
        rst_n = 1'b0;
        exp_q.delete();
        done_expected = done_seen;
        #1;
        check_reset_outputs("midcommit_reset");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("writes_after_reset", writes_seen, base + 2);
        check("busy_after_reset", busy, 0);

        // Loader still works after the abandoned commit
        rand_frame(8'd10, 8'd6, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #400000;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side writer for the 8-bit core's instruction-memory load port (write enable, 5-bit address, 8-bit data).
- Accepts a framed byte stream over a valid/ready interface and buffers the whole payload internally.
- Verifies an 8-bit checksum, then commits the payload to instruction memory as back-to-back single-cycle writes.
- Holds the core in load mode from the first payload byte until the commit finishes.

Parameters:
- MEM_DEPTH, 25, number of instruction-memory locations; legal addresses are 0..MEM_DEPTH-1.
- ADDR_W, 5, width of the memory address.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle (transfer = in_valid & in_ready).
- mem_we  output  1  instruction-memory write strobe, one cycle per byte.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  8  write data.
- cpu_hold  output  1  high while a frame is being received or committed; drives the core's write-mode input.
- done  output  1  one-cycle pulse after a successful commit.
- err  output  1  sticky error flag.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state, including mid-commit):
  - state=IDLE; in_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; cpu_hold=0; done=0; err=0; busy=0.
  - Buffer contents become don't-care.
  - Any partial commit is abandoned; no further writes are issued.
- Frame format: SYNC, ADDR, LEN, D0..D(LEN-1), CSUM.
  - The checksum is valid when (ADDR+LEN+sum(Di)+CSUM) mod 256 == 0. SYNC is excluded from the sum.
- States: IDLE, GET_ADDR, GET_LEN, GET_DATA, GET_CSUM, COMMIT, ERROR.
- in_ready:
  - 1 in IDLE, GET_ADDR, GET_LEN, GET_DATA, GET_CSUM, and ERROR.
  - 0 in COMMIT.
- IDLE:
  - Accepted byte == SYNC_BYTE: go to GET_ADDR; clear err; clear the running sum.
  - Any other accepted byte is dropped and the state stays IDLE.
- GET_ADDR:
  - Latch the byte as start address and add it to the sum.
  - Byte >= MEM_DEPTH: go to ERROR.
- GET_LEN:
  - Latch the byte as length and add it to the sum.
  - Go to ERROR if LEN == 0 or ADDR+LEN > MEM_DEPTH; compute this with 9-bit arithmetic, no wrap.
  - Otherwise go to GET_DATA and assert cpu_hold.
- GET_DATA:
  - Store byte i into buffer[i] and add it to the sum.
  - After LEN bytes, go to GET_CSUM.
- GET_CSUM:
  - Add the byte to the sum.
  - Sum == 0: go to COMMIT.
  - Sum != 0: go to ERROR; memory is untouched.
- COMMIT:
  - mem_we=1 for exactly LEN consecutive cycles.
  - Cycle k drives mem_addr = ADDR+k and mem_wdata = buffer[k].
  - mem_addr never exceeds MEM_DEPTH-1.
  - In the cycle after the last write: mem_we=0, cpu_hold=0, done=1 for one cycle, state=IDLE.
- ERROR:
  - Set err=1 and cpu_hold=0, then go to IDLE on the next cycle. err stays set until the next SYNC is accepted.
  - No memory write ever occurs for an errored frame.
- mem_we is 0 in every state other than COMMIT. mem_addr and mem_wdata hold their last values when mem_we=0.
- A SYNC value inside ADDR, LEN, data or CSUM positions is treated as data; there is no mid-frame resync.
- in_valid low stalls reception indefinitely; there is no timeout.
- busy=1 whenever state != IDLE.
- Latency: first mem_we is asserted the cycle after the CSUM byte is accepted; done follows LEN+1 cycles after the CSUM byte is accepted.

Test Plan:
- Load at 0, 3 bytes: send A5,00,03,01,2A,0A, then CSUM=C8 (sum of 00+03+01+2A+0A = 0x38; 0x38+0xC8 = 0x100). Expect mem_we for 3 cycles at addresses 0,1,2 with data 01,2A,0A; done pulse; err=0; cpu_hold high from LEN accept to commit end.
- Bad checksum: same frame with CSUM=C7. Expect no mem_we; err=1; state returns to IDLE. A following good frame clears err and loads correctly.
- Boundary fit: ADDR=0x16, LEN=3 (ends at 24). Expect writes at 22,23,24.
- Boundary overflow: ADDR=0x17, LEN=3. Expect ERROR after LEN, err=1, no writes. Also check LEN=0 and ADDR=0x19 each error.
- Garbage and stall: bytes 00,FF,13 before A5 are dropped. Toggle in_valid randomly mid-frame; expect the identical write sequence. Confirm in_ready=0 throughout COMMIT.
- Reset mid-commit: assert rst_n low during the 2nd write of a 5-byte commit. Expect all outputs at reset values immediately, with no further mem_we after release.
